// File: rtl/bcd_mod_counter_pkg.sv
// Shared constants, per-digit control payload and BCD helpers for the
// modulo-N BCD counter.
package bcd_mod_counter_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned MAX_W      = BCD_W * MAX_DIGITS;

  localparam logic [BCD_W-1:0] DIGIT_0 = BCD_W'(0);
  localparam logic [BCD_W-1:0] DIGIT_9 = BCD_W'(9);

  // Per-digit update request; priority inside the digit is clear > set > inc > dec.
  typedef struct packed {
    logic             clear;
    logic             set;
    logic             inc;
    logic             dec;
    logic [BCD_W-1:0] wrap_to;
  } digit_ctrl_t;

  // Integer to packed BCD, least significant digit in [3:0].
  function automatic logic [MAX_W-1:0] int_to_bcd(input int unsigned value);
    logic [MAX_W-1:0] bcd;
    int unsigned      rem;
    bcd = '0;
    rem = value;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      bcd[i*BCD_W +: BCD_W] = BCD_W'(rem % 10);
      rem = rem / 10;
    end
    return bcd;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control/status bundle between a counter field and whoever drives it.
interface bcd_mod_counter_if #(
  parameter int unsigned DIGITS = 2
);
  import bcd_mod_counter_pkg::*;

  localparam int unsigned W = BCD_W * DIGITS;

  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         carry;
  logic         at_term;
  logic         load_err;

  modport master (
    output en, up, load, load_val,
    input  q, carry, at_term, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output q, carry, at_term, load_err
  );

endinterface

// File: rtl/bcd_mod_counter_digit.sv
// One decade of the counter: holds a 0..9 value and flags 9/0 so the
// parent can ripple increments and borrows within a single cycle.
module bcd_mod_counter_digit
  import bcd_mod_counter_pkg::*;
(
  input  logic             clk,
  input  digit_ctrl_t      ctrl_i,
  output logic [BCD_W-1:0] value_o,
  output logic             is_nine_c_o,
  output logic             is_zero_c_o
);

  logic [BCD_W-1:0] value_q;
  logic [BCD_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (ctrl_i.clear) begin
      value_d = DIGIT_0;
    end else if (ctrl_i.set) begin
      value_d = ctrl_i.wrap_to;
    end else if (ctrl_i.inc) begin
      value_d = (value_q == DIGIT_9) ? DIGIT_0 : value_q + BCD_W'(1);
    end else if (ctrl_i.dec) begin
      value_d = (value_q == DIGIT_0) ? DIGIT_9 : value_q - BCD_W'(1);
    end
  end

  // Synchronous reset reaches the digit through ctrl_i.clear.
  always_ff @(posedge clk) begin
    value_q <= value_d;
  end

  assign value_o     = value_q;
  assign is_nine_c_o = (value_q == DIGIT_9);
  assign is_zero_c_o = (value_q == DIGIT_0);

endmodule

// File: rtl/bcd_mod_counter.sv
// Modulo-MODULUS BCD up/down counter with parallel load, wrap strobe for
// cascading into the next field, and rejected-load strobe.
module bcd_mod_counter
  import bcd_mod_counter_pkg::*;
#(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MODULUS = 60
) (
  input  logic             clk,
  input  logic             reset,
  bcd_mod_counter_if.slave bus
);

  localparam int unsigned W        = BCD_W * DIGITS;
  localparam logic [W-1:0] TERM_MAX = W'(int_to_bcd(MODULUS - 1));

  logic [W-1:0]      q;
  logic [DIGITS-1:0] nine_c;
  logic [DIGITS-1:0] zero_c;
  logic [DIGITS-1:0] inc_en_c;
  logic [DIGITS-1:0] dec_en_c;
  digit_ctrl_t       ctrl_c [DIGITS];

  logic load_ok_c;
  logic load_accept_c;
  logic at_max_c;
  logic at_zero_c;
  logic tick_c;
  logic wrap_up_c;
  logic wrap_dn_c;

  logic carry_q;
  logic carry_d;
  logic load_err_q;
  logic load_err_d;

  // Ripple flags out of the top digit have nothing left to feed.
  logic unused_top_nine;
  assign unused_top_nine = nine_c[DIGITS-1];

  // A load is legal only if every nibble is a decimal digit and the value
  // is in range; for valid BCD the packed compare orders like decimal.
  always_comb begin
    load_ok_c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.load_val[i*BCD_W +: BCD_W] > DIGIT_9) begin
        load_ok_c = 1'b0;
      end
    end
    if (bus.load_val > TERM_MAX) begin
      load_ok_c = 1'b0;
    end
  end

  assign load_accept_c = bus.load & load_ok_c;
  assign at_max_c      = (q == TERM_MAX);
  assign at_zero_c     = &zero_c;
  assign tick_c        = bus.en & ~bus.load;
  assign wrap_up_c     = tick_c &  bus.up & at_max_c;
  assign wrap_dn_c     = tick_c & ~bus.up & at_zero_c;

  // Per-digit controls; wraps are applied to all digits at once, ordinary
  // steps ripple from the LSD through digits sitting at 9 (up) or 0 (down).
  always_comb begin
    inc_en_c    = '0;
    dec_en_c    = '0;
    inc_en_c[0] = tick_c &  bus.up & ~at_max_c;
    dec_en_c[0] = tick_c & ~bus.up & ~at_zero_c;
    for (int i = 1; i < int'(DIGITS); i++) begin
      inc_en_c[i] = inc_en_c[i-1] & nine_c[i-1];
      dec_en_c[i] = dec_en_c[i-1] & zero_c[i-1];
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      ctrl_c[i].clear   = reset | wrap_up_c;
      ctrl_c[i].set     = ~reset & (load_accept_c | wrap_dn_c);
      ctrl_c[i].inc     = inc_en_c[i];
      ctrl_c[i].dec     = dec_en_c[i];
      ctrl_c[i].wrap_to = bus.load ? bus.load_val[i*BCD_W +: BCD_W]
                                   : TERM_MAX[i*BCD_W +: BCD_W];
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    bcd_mod_counter_digit u_digit (
      .clk         (clk),
      .ctrl_i      (ctrl_c[g]),
      .value_o     (q[g*BCD_W +: BCD_W]),
      .is_nine_c_o (nine_c[g]),
      .is_zero_c_o (zero_c[g])
    );
  end

  always_comb begin
    carry_d    = ~reset & (wrap_up_c | wrap_dn_c);
    load_err_d = ~reset & bus.load & ~load_ok_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.q        = q;
  assign bus.carry    = carry_q;
  assign bus.load_err = load_err_q;
  assign bus.at_term  = bus.up ? at_max_c : at_zero_c;

endmodule
